tx_gate_scheduler: RTL and testbench
====================================

Name: tx_gate_scheduler

Overview:
- Time-aware gate scheduler (TSN gate control list, GCL) that drives the tx_selection block.
- Steps through a programmable list of gate entries, timed from the PTP-synchronised nanosecond counter, starting at a configured base time.
- Outputs a per-stream gate vector, plus pkt_gen_ready / pkt_gen_finish pulses that open and close the packet-generator window.

Parameters:
- NUM_ENTRIES, 8, GCL depth; power of two, 2..16.
- NS_PER_CLK, 8, nanoseconds sync_time_ptp_ns advances per clk.
- NS_WRAP, 1_000_000_000, wrap value of sync_time_ptp_ns.
- IDLE_MASK, 2'b10, gate_open value while not running (ps2pl open).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- sync_time_ptp_ns  in  32  PTP time in ns; advances NS_PER_CLK per cycle; wraps NS_WRAP-1 -> 0.
- cfg_enable  in  1  level; 1 = run schedule.
- cfg_base_ns  in  32  cycle start time in ns; sampled on cfg_enable rise.
- cfg_num_entries  in  $clog2(NUM_ENTRIES)+1  active entry count; sampled on cfg_enable rise.
- cfg_wr_en  in  1  GCL table write strobe.
- cfg_wr_addr  in  $clog2(NUM_ENTRIES)  table index.
- cfg_wr_mask  in  2  gate mask; bit0 = pkt_gen, bit1 = ps2pl.
- cfg_wr_interval  in  32  entry duration in ns.
- gate_open  out  2  current registered gate mask.
- pkt_gen_ready  out  1  one-cycle pulse when gate_open[0] goes 0->1.
- pkt_gen_finish  out  1  one-cycle pulse when gate_open[0] goes 1->0.
- cur_entry  out  $clog2(NUM_ENTRIES)  index of the active entry.
- cycle_start  out  1  one-cycle pulse each time entry 0 is loaded.
- running  out  1  high in RUN state.
- cfg_error  out  1  sticky until next cfg_enable rise; set on an invalid configuration.

Behaviour:
- Reset values: gate_open = IDLE_MASK; all pulses, cur_entry, running, cfg_error = 0; state IDLE; table masks = IDLE_MASK, intervals = 0.
- Table write: takes effect the cycle after cfg_wr_en; allowed in any state. A write to the active entry does not change the loaded remaining count; it is used on the next load.
- FSM state IDLE:
  - On cfg_enable rising edge, sample base and count.
  - If count = 0, count > NUM_ENTRIES, or base >= NS_WRAP: set cfg_error and stay in IDLE.
  - Otherwise go to WAIT_BASE.
- FSM state WAIT_BASE:
  - Each cycle compute d = (sync_time_ptp_ns - base) mod NS_WRAP, with NS_WRAP added on borrow, using 33-bit arithmetic.
  - When d < NS_PER_CLK: load entry 0, go to RUN.
  - Effects of the load, visible the next cycle: gate_open = mask0, cycle_start = 1, remaining = max(interval0, NS_PER_CLK).
- FSM state RUN:
  - Each cycle, if remaining > NS_PER_CLK: remaining -= NS_PER_CLK.
  - Otherwise load entry (cur_entry+1) and wrap to 0 at count. On wrap, pulse cycle_start.
  - An interval of 0 lasts one cycle; an interval that is not a multiple of NS_PER_CLK rounds up.
- Leaving RUN/WAIT_BASE:
  - cfg_enable low in RUN or WAIT_BASE returns to IDLE next cycle with gate_open = IDLE_MASK.
  - If gate_open[0] was 1, pkt_gen_finish pulses in that same cycle.
- Pulse generation:
  - pkt_gen_ready and pkt_gen_finish are registered edges of gate_open[0] and coincide with the gate_open change.
  - They never assert in the same cycle.
  - Consecutive entries with identical bit0 produce no pulse.
- Reset mid-RUN: immediate return to reset values; no finish pulse.
- PTP time jump during RUN: ignored; the schedule free-runs on the clk count. Only WAIT_BASE compares against the time.

Decomposition:
- Package tsn_sched_pkg holds:
  - NS_WRAP;
  - gate bit indices GATE_PKT_GEN = 0 and GATE_PS2PL = 1;
  - state enum IDLE / WAIT_BASE / RUN;
  - the gcl_entry struct {mask[1:0], interval[31:0]}.
- Sub-module gcl_entry_table: register file of NUM_ENTRIES gcl_entry entries, with one synchronous write port and one combinational read port indexed by the next-entry pointer.

Test Plan:
- Start of schedule:
  - Stimulus: reset with time 999_999_000; entries e0 = {01, 80}, e1 = {10, 160}; num = 2; base = 999_999_040; enable.
  - Response: match 5 cycles after reset release; next cycle gate_open = 01 with pkt_gen_ready and cycle_start both pulsing.
- Steady-state cycling:
  - Same setup as above.
  - Response: gate_open = 01 for 10 cycles, then 10 with pkt_gen_finish for 20 cycles; cycle_start every 30 cycles; cur_entry alternates 0/1.
- Wrap-around base:
  - Stimulus: base = 16 with time starting at 999_999_984.
  - Response: start occurs after the time wrap (d < 8 at time 16), not before.
- Degenerate entries:
  - Stimulus: e0 = {01, 0}, e1 = {01, 12}, e2 = {00, 8}; num = 3.
  - Response: e0 lasts 1 cycle and e1 lasts 2 cycles, with no pulse between them; a finish pulse at e2.
- Disable while gate open:
  - Stimulus: drop cfg_enable while gate_open = 01.
  - Response: next cycle gate_open = 10 with a pkt_gen_finish pulse and running = 0.
- Invalid configuration:
  - Stimulus: num = 0, or base = 1_000_000_000.
  - Response: cfg_error = 1, state stays IDLE, gate_open = 10, no pulses.

Source files
------------

// File: rtl/tsn_sched_pkg.sv
// Shared types and constants for the TSN gate scheduler.
// Gate bit positions, FSM states and the GCL entry layout live here.
package tsn_sched_pkg;

    localparam int unsigned NS_WRAP      = 1_000_000_000;
    localparam int          GATE_PKT_GEN = 0;
    localparam int          GATE_PS2PL   = 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BASE,
        RUN
    } sched_state_e;

    typedef struct packed {
        logic [1:0]  mask;
        logic [31:0] interval;
    } gcl_entry_t;

endpackage

// File: rtl/gcl_entry_table.sv
// Gate control list storage: one synchronous write port, one combinational read port.
module gcl_entry_table #(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter logic [1:0]  IDLE_MASK   = 2'b10
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [$clog2(NUM_ENTRIES)-1:0] wr_addr,
    input  logic [1:0]                     wr_mask,
    input  logic [31:0]                    wr_interval,
    input  logic [$clog2(NUM_ENTRIES)-1:0] rd_addr,
    output logic [1:0]                     rd_mask,
    output logic [31:0]                    rd_interval
);
    import tsn_sched_pkg::*;

    localparam int AW = $clog2(NUM_ENTRIES);

    gcl_entry_t entries [NUM_ENTRIES];

    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
        gcl_entry_t entry_reg;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                entry_reg.mask     <= IDLE_MASK;
                entry_reg.interval <= '0;
            end else if (wr_en && (wr_addr == AW'(gi))) begin
                entry_reg.mask     <= wr_mask;
                entry_reg.interval <= wr_interval;
            end
        end

        assign entries[gi] = entry_reg;
    end

    assign rd_mask     = entries[rd_addr].mask;
    assign rd_interval = entries[rd_addr].interval;

endmodule

// File: rtl/tx_gate_scheduler.sv
// Time-aware gate scheduler: waits for the PTP base time, then free-runs the
// gate control list on the clk count and drives the per-stream gate vector.
module tx_gate_scheduler #(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned NS_PER_CLK  = 8,
    parameter int unsigned NS_WRAP     = tsn_sched_pkg::NS_WRAP,
    parameter logic [1:0]  IDLE_MASK   = 2'b10
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [31:0]                    sync_time_ptp_ns,
    input  logic                           cfg_enable,
    input  logic [31:0]                    cfg_base_ns,
    input  logic [$clog2(NUM_ENTRIES):0]   cfg_num_entries,
    input  logic                           cfg_wr_en,
    input  logic [$clog2(NUM_ENTRIES)-1:0] cfg_wr_addr,
    input  logic [1:0]                     cfg_wr_mask,
    input  logic [31:0]                    cfg_wr_interval,
    output logic [1:0]                     gate_open,
    output logic                           pkt_gen_ready,
    output logic                           pkt_gen_finish,
    output logic [$clog2(NUM_ENTRIES)-1:0] cur_entry,
    output logic                           cycle_start,
    output logic                           running,
    output logic                           cfg_error
);
    import tsn_sched_pkg::*;

    localparam int          IW        = $clog2(NUM_ENTRIES);
    localparam int          CW        = IW + 1;
    localparam logic [CW-1:0] MAX_COUNT = CW'(NUM_ENTRIES);
    localparam logic [31:0] NPC       = 32'(NS_PER_CLK);
    localparam logic [31:0] WRAP_NS   = 32'(NS_WRAP);

    sched_state_e  state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic [31:0]   base_reg, base_next;
    logic [31:0]   remaining_reg, remaining_next;
    logic [IW-1:0] entry_reg, entry_next;
    logic [1:0]    gate_reg, gate_next;
    logic          ready_reg, ready_next;
    logic          finish_reg, finish_next;
    logic          cycle_start_reg, cycle_start_next;
    logic          error_reg, error_next;
    logic          enable_d_reg;

    logic          enable_rise;
    logic          load;
    logic [CW-1:0] entry_inc;
    logic [IW-1:0] next_idx;
    logic [1:0]    rd_mask;
    logic [31:0]   rd_interval;
    logic [32:0]   diff_raw;
    logic [32:0]   diff_ns;

    gcl_entry_table #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .IDLE_MASK   (IDLE_MASK)
    ) u_table (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (cfg_wr_en),
        .wr_addr     (cfg_wr_addr),
        .wr_mask     (cfg_wr_mask),
        .wr_interval (cfg_wr_interval),
        .rd_addr     (next_idx),
        .rd_mask     (rd_mask),
        .rd_interval (rd_interval)
    );

    assign enable_rise = cfg_enable & ~enable_d_reg;
    assign entry_inc   = {1'b0, entry_reg} + CW'(1);
    assign next_idx    = ((state_reg != RUN) || (entry_inc >= count_reg)) ? '0 : entry_inc[IW-1:0];

    // Distance past the base time, modulo the PTP nanosecond wrap.
    assign diff_raw = {1'b0, sync_time_ptp_ns} - {1'b0, base_reg};
    assign diff_ns  = diff_raw[32] ? (diff_raw + {1'b0, WRAP_NS}) : diff_raw;

    always_comb begin
        state_next       = state_reg;
        count_next       = count_reg;
        base_next        = base_reg;
        remaining_next   = remaining_reg;
        entry_next       = entry_reg;
        gate_next        = gate_reg;
        error_next       = error_reg;
        cycle_start_next = 1'b0;
        load             = 1'b0;

        case (state_reg)
            IDLE: begin
                if (enable_rise) begin
                    base_next  = cfg_base_ns;
                    count_next = cfg_num_entries;
                    if ((cfg_num_entries == '0) || (cfg_num_entries > MAX_COUNT) ||
                        (cfg_base_ns >= WRAP_NS)) begin
                        error_next = 1'b1;
                    end else begin
                        error_next = 1'b0;
                        state_next = WAIT_BASE;
                    end
                end
            end
            WAIT_BASE: begin
                if (!cfg_enable) begin
                    state_next = IDLE;
                end else if (diff_ns < {1'b0, NPC}) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!cfg_enable) begin
                    state_next = IDLE;
                end else if (remaining_reg > NPC) begin
                    remaining_next = remaining_reg - NPC;
                end else begin
                    load = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (state_next == IDLE && state_reg != IDLE) begin
            gate_next  = IDLE_MASK;
            entry_next = '0;
        end

        // Zero-length entries still occupy one clock.
        if (load) begin
            entry_next       = next_idx;
            gate_next        = rd_mask;
            remaining_next   = (rd_interval < NPC) ? NPC : rd_interval;
            cycle_start_next = (next_idx == '0);
        end

        ready_next  = ~gate_reg[GATE_PKT_GEN] &  gate_next[GATE_PKT_GEN];
        finish_next =  gate_reg[GATE_PKT_GEN] & ~gate_next[GATE_PKT_GEN];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            base_reg        <= '0;
            remaining_reg   <= '0;
            entry_reg       <= '0;
            gate_reg        <= IDLE_MASK;
            ready_reg       <= 1'b0;
            finish_reg      <= 1'b0;
            cycle_start_reg <= 1'b0;
            error_reg       <= 1'b0;
            enable_d_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            base_reg        <= base_next;
            remaining_reg   <= remaining_next;
            entry_reg       <= entry_next;
            gate_reg        <= gate_next;
            ready_reg       <= ready_next;
            finish_reg      <= finish_next;
            cycle_start_reg <= cycle_start_next;
            error_reg       <= error_next;
            enable_d_reg    <= cfg_enable;
        end
    end

    assign gate_open      = gate_reg;
    assign pkt_gen_ready  = ready_reg;
    assign pkt_gen_finish = finish_reg;
    assign cur_entry      = entry_reg;
    assign cycle_start    = cycle_start_reg;
    assign running        = (state_reg == RUN);
    assign cfg_error      = error_reg;

endmodule

// File: tb/tb_tx_gate_scheduler.sv
// Directed bench for tx_gate_scheduler; outputs are packed into one vector
// {gate_open, ready, finish, cur_entry, cycle_start, running, cfg_error} per check.
module tb_tx_gate_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ptp = '0;
    logic        cfg_enable = 1'b0;
    logic [31:0] cfg_base_ns = '0;
    logic [3:0]  cfg_num_entries = '0;
    logic        cfg_wr_en = 1'b0;
    logic [2:0]  cfg_wr_addr = '0;
    logic [1:0]  cfg_wr_mask = '0;
    logic [31:0] cfg_wr_interval = '0;
    logic [1:0]  gate_open;
    logic        pkt_gen_ready, pkt_gen_finish, cycle_start, running, cfg_error;
    logic [2:0]  cur_entry;

    int tests_run = 0;
    int tests_failed = 0;

    tx_gate_scheduler dut (
        .clk              (clk),
        .reset            (reset),
        .sync_time_ptp_ns (ptp),
        .cfg_enable       (cfg_enable),
        .cfg_base_ns      (cfg_base_ns),
        .cfg_num_entries  (cfg_num_entries),
        .cfg_wr_en        (cfg_wr_en),
        .cfg_wr_addr      (cfg_wr_addr),
        .cfg_wr_mask      (cfg_wr_mask),
        .cfg_wr_interval  (cfg_wr_interval),
        .gate_open        (gate_open),
        .pkt_gen_ready    (pkt_gen_ready),
        .pkt_gen_finish   (pkt_gen_finish),
        .cur_entry        (cur_entry),
        .cycle_start      (cycle_start),
        .running          (running),
        .cfg_error        (cfg_error)
    );

    always #5 clk = ~clk;

    logic [9:0] obs;
    assign obs = {gate_open, pkt_gen_ready, pkt_gen_finish, cur_entry, cycle_start, running, cfg_error};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %03h expected %03h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] vec(input logic [1:0] g, input logic r, input logic f,
                                        input logic [2:0] e, input logic cs, input logic run,
                                        input logic err);
        return {22'd0, g, r, f, e, cs, run, err};
    endfunction

    // One clock edge; PTP time advances 8 ns and wraps at one second.
    task automatic step();
        @(posedge clk);
        #1;
        if (ptp + 32'd8 >= 32'd1_000_000_000) ptp = ptp + 32'd8 - 32'd1_000_000_000;
        else ptp = ptp + 32'd8;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [1:0] mask, input logic [31:0] ival);
        cfg_wr_en = 1'b1;
        cfg_wr_addr = addr;
        cfg_wr_mask = mask;
        cfg_wr_interval = ival;
        step();
        cfg_wr_en = 1'b0;
        $display("[TB] write e%0d mask=%b interval=%0d", addr, mask, ival);
    endtask

    task automatic start(input logic [3:0] num, input logic [31:0] base, input logic [31:0] t0);
        cfg_num_entries = num;
        cfg_base_ns = base;
        ptp = t0;
        cfg_enable = 1'b1;
        $display("[TB] enable num=%0d base=%0d time=%0d", num, base, t0);
    endtask

    initial begin
        int ph;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_state", obs, vec(2'b10, 0, 0, 0, 0, 0, 0));

        wr(0, 2'b01, 80);
        wr(1, 2'b10, 160);

        // Start of schedule and steady-state cycling.
        start(2, 32'd999_999_040, 32'd999_999_000);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("start_wait%0d", k), obs, vec(2'b10, 0, 0, 0, 0, 0, 0));
        end
        for (int c = 0; c <= 60; c++) begin
            step();
            ph = c % 30;
            check($sformatf("steady_c%0d", c), obs,
                  vec((ph < 10) ? 2'b01 : 2'b10, ph == 0, ph == 10, (ph < 10) ? 3'd0 : 3'd1,
                      ph == 0, 1, 0));
        end
        $display("[TB] steady cycling observed for 61 cycles");

        // Disable while gate open.
        cfg_enable = 1'b0;
        step();
        check("disable_open", obs, vec(2'b10, 0, 1, 0, 0, 0, 0));
        step();
        check("disable_idle", obs, vec(2'b10, 0, 0, 0, 0, 0, 0));

        // Base just after the one-second wrap.
        start(2, 32'd16, 32'd999_999_984);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("wrap_wait%0d", k), obs, vec(2'b10, 0, 0, 0, 0, 0, 0));
        end
        step();
        check("wrap_start", obs, vec(2'b01, 1, 0, 0, 1, 1, 0));
        cfg_enable = 1'b0;
        step();
        check("wrap_disable", obs, vec(2'b10, 0, 1, 0, 0, 0, 0));

        // Degenerate intervals.
        wr(0, 2'b01, 0);
        wr(1, 2'b01, 12);
        wr(2, 2'b00, 8);
        start(3, 32'd1008, 32'd1000);
        step();
        check("degen_wait", obs, vec(2'b10, 0, 0, 0, 0, 0, 0));
        step();
        check("degen_e0", obs, vec(2'b01, 1, 0, 0, 1, 1, 0));
        step();
        check("degen_e1a", obs, vec(2'b01, 0, 0, 1, 0, 1, 0));
        step();
        check("degen_e1b", obs, vec(2'b01, 0, 0, 1, 0, 1, 0));
        step();
        check("degen_e2", obs, vec(2'b00, 0, 1, 2, 0, 1, 0));
        step();
        check("degen_wrap", obs, vec(2'b01, 1, 0, 0, 1, 1, 0));

        // Asynchronous reset mid-run, then confirm the table came back to idle contents.
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("reset_midrun", obs, vec(2'b10, 0, 0, 0, 0, 0, 0));
        cfg_enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        start(1, 32'd2008, 32'd2000);
        step();
        check("tblrst_wait", obs, vec(2'b10, 0, 0, 0, 0, 0, 0));
        step();
        check("tblrst_load", obs, vec(2'b10, 0, 0, 0, 1, 1, 0));
        step();
        check("tblrst_reload", obs, vec(2'b10, 0, 0, 0, 1, 1, 0));
        cfg_enable = 1'b0;
        step();
        check("tblrst_disable", obs, vec(2'b10, 0, 0, 0, 0, 0, 0));

        // Invalid configurations.
        start(0, 32'd100, 32'd5000);
        step();
        check("inv_num0", obs, vec(2'b10, 0, 0, 0, 0, 0, 1));
        step();
        check("inv_num0_hold", obs, vec(2'b10, 0, 0, 0, 0, 0, 1));
        cfg_enable = 1'b0;
        step();
        check("inv_sticky", obs, vec(2'b10, 0, 0, 0, 0, 0, 1));
        start(2, 32'd1_000_000_000, 32'd5000);
        step();
        check("inv_base", obs, vec(2'b10, 0, 0, 0, 0, 0, 1));
        cfg_enable = 1'b0;
        step();
        start(9, 32'd100, 32'd5000);
        step();
        check("inv_num9", obs, vec(2'b10, 0, 0, 0, 0, 0, 1));
        cfg_enable = 1'b0;
        step();
        start(8, 32'd500, 32'd100000);
        step();
        check("valid_clears_err", obs, vec(2'b10, 0, 0, 0, 0, 0, 0));
        cfg_enable = 1'b0;
        step();
        check("valid_disable", obs, vec(2'b10, 0, 0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
